alu_operand_sequencer: RTL and testbench
========================================

# alu_operand_sequencer

Sequencing stage wrapped around the 8-bit add/subtract datapath. Holds a four-entry 8-bit register file and drives the adder's `Aout`, `Bout` and `Add_Sub` inputs from registered operands. Captures the adder's `R`, `Cout`, `OVR`, `Neg` and `Zero` on a fixed cycle and writes the result back to a destination register. Runs one operation per `Start`/`Done` handshake, so the combinational adder only ever sees stable, registered operands.

## Interface
Parameters:
- `DEPTH`, 4: register-file entries; the address width is fixed at 2 bits.

Ports:
- `Clock`  in  1  sole clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `Start`  in  1  request one operation; sampled only in IDLE.
- `Op`  in  1  0 = add, 1 = subtract; latched with `Start`.
- `SrcA`, `SrcB`, `Dst`  in  2 each  operand and destination addresses; latched with `Start`.
- `LoadEn`  in  1  external register write; honoured only in IDLE.
- `LoadAddr`  in  2  external write address.
- `LoadData`  in  8  external write data.
- `Aout`, `Bout`  out  8 each  operand registers driving the adder.
- `Add_Sub`  out  1  registered `Op` driving the adder.
- `R`  in  8  adder result.
- `Cout`, `OVR`, `Neg`, `Zero`  in  1 each  adder flags.
- `Result`  out  8  last written-back value.
- `Flags`  out  4  status register, ordered {Cout, OVR, Neg, Zero}.
- `Busy`  out  1  high in READ, EXEC and WB.
- `Done`  out  1  one-cycle pulse in WB.

## Operation
- **IDLE**
  - `Start`=1 latches `Op`/`SrcA`/`SrcB`/`Dst` and moves to READ.
  - `LoadEn`=1 writes `regs[LoadAddr]` <= `LoadData`.
  - If `LoadEn` and `Start` occur in the same cycle, the load commits first. READ then sees the new value, including when `LoadAddr` equals `SrcA` or `SrcB`.
- **READ**: `Aout` <= `regs[SrcA]`, `Bout` <= `regs[SrcB]`, `Add_Sub` <= `Op`. `SrcA` equal to `SrcB` is legal.
- **EXEC**: no register updates; the adder settles on the stable inputs.
- **WB**
  - Samples `R` and the flags.
  - `regs[Dst]` <= written value; `Result` <= written value.
  - `Flags` <= {`Cout`, `OVR`, `Neg`, `Zero`}.
  - `Done`=1; next state is IDLE.
- `Start` and `LoadEn` are ignored in READ, EXEC and WB. They are not queued.
- Arithmetic is performed entirely by the adder: 8-bit two's complement, wrap-around mod 256. This block does no arithmetic except saturation (see Configuration).
- `Aout`, `Bout` and `Add_Sub` hold their values after WB until the next READ.

## Timing
- **Reset** (asynchronous, immediate, legal in any state):
  - All `regs`, `Aout`, `Bout`, `Result` = 0x00.
  - `Add_Sub`=0, `Flags`=4'b0000, `Busy`=0, `Done`=0, state = IDLE.
  - An operation in flight is discarded with no write-back.
- `Start` sampled at edge N puts the block in READ during cycle N+1, EXEC during N+2 and WB during N+3.
  - `Done` is high during N+3.
  - `Regs`, `Result` and `Flags` update at the end of N+3.
- Latency from `Start` to `Done` is 3 cycles. Throughput is one operation per 4 cycles; the earliest next `Start` is accepted in cycle N+4.
- `Busy` is high exactly during cycles N+1 through N+3.
- A result written in WB is readable by the next operation's READ, so no forwarding is needed.

## Configuration
- `ALU_SAT_WB_EN` defined:
  - In WB, if `OVR`=1, the written value is 0x7F when `Aout[7]`=0 and 0x80 when `Aout[7]`=1.
  - `Flags` still record the raw adder flags, with `OVR`=1.
- `ALU_SAT_WB_EN` undefined: the written value is always `R` (wrap-around).

## Test plan
- **Reset**: assert `Reset` mid-EXEC -> all outputs take their reset values immediately; no write to `Dst`; `Done` stays 0.
- **Add**: load r0=0x05 and r1=0x03; `Start` with Op=0, SrcA=0, SrcB=1, Dst=2 -> `Done` 3 cycles later; r2=0x08; `Result`=0x08; `Flags`=0000.
- **Subtract to zero**: r0=0x05, r1=0x05; Op=1, Dst=3 -> `Result`=0x00; `Flags`=1001 (Cout=1, Zero=1).
- **Overflow**: r0=0x7F, r1=0x01; Op=0 -> without the macro, `Result`=0x80 and `Flags`=0110; with `ALU_SAT_WB_EN`, `Result`=0x7F and `Flags`=0110.
- **Same-cycle load and start**: in IDLE, `LoadEn` with LoadAddr=0, LoadData=0x10, together with `Start` (SrcA=0, SrcB=0, Op=0) -> `Aout`=`Bout`=0x10 in EXEC; `Result`=0x20.
- **Busy ignores inputs**: pulse `Start` and `LoadEn` during EXEC -> no new operation and no register write; `Busy` deasserts after a single `Done`.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the external 8-bit add/subtract datapath: 4-entry register file,
// registered adder operands, fixed-cycle write-back. Optional saturation: ALU_SAT_WB_EN.
module alu_operand_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Op,
  input  logic [1:0] SrcA,
  input  logic [1:0] SrcB,
  input  logic [1:0] Dst,
  input  logic       LoadEn,
  input  logic [1:0] LoadAddr,
  input  logic [7:0] LoadData,
  output logic [7:0] Aout,
  output logic [7:0] Bout,
  output logic       Add_Sub,
  input  logic [7:0] R,
  input  logic       Cout,
  input  logic       OVR,
  input  logic       Neg,
  input  logic       Zero,
  output logic [7:0] Result,
  output logic [3:0] Flags,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_op;
  logic [1:0] r_src_a;
  logic [1:0] r_src_b;
  logic [1:0] r_dst;
  logic [7:0] r_regs [DEPTH];
  logic [7:0] w_wb_data;

  // Value committed to the destination register in WB
  always_comb begin
`ifdef ALU_SAT_WB_EN
    if (OVR) begin
      w_wb_data = Aout[7] ? 8'h80 : 8'h7F;
    end else begin
      w_wb_data = R;
    end
`else
    w_wb_data = R;
`endif
  end

  // Sequencer FSM, register file and all registered outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
      r_src_a <= 2'd0;
      r_src_b <= 2'd0;
      r_dst   <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= 8'h00;
      end
      Aout    <= 8'h00;
      Bout    <= 8'h00;
      Add_Sub <= 1'b0;
      Result  <= 8'h00;
      Flags   <= 4'b0000;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The load lands at this edge, so a same-cycle Start reads it in READ
          if (LoadEn) begin
            r_regs[LoadAddr] <= LoadData;
          end
          if (Start) begin
            r_op    <= Op;
            r_src_a <= SrcA;
            r_src_b <= SrcB;
            r_dst   <= Dst;
            Busy    <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          Aout    <= r_regs[r_src_a];
          Bout    <= r_regs[r_src_b];
          Add_Sub <= r_op;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          Done    <= 1'b1;
          r_state <= S_WB;
        end
        S_WB: begin
          r_regs[r_dst] <= w_wb_data;
          Result        <= w_wb_data;
          Flags         <= {Cout, OVR, Neg, Zero};
          Done          <= 1'b0;
          Busy          <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: the bench plays the adder, and expected
// results come from an integer-arithmetic model of the register file.
module tb_alu_operand_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Op = 1'b0;
  logic [1:0] SrcA = 2'd0, SrcB = 2'd0, Dst = 2'd0;
  logic       LoadEn = 1'b0;
  logic [1:0] LoadAddr = 2'd0;
  logic [7:0] LoadData = 8'h00;
  logic [7:0] Aout, Bout, R, Result;
  logic       Add_Sub, Cout, OVR, Neg, Zero, Busy, Done;
  logic [3:0] Flags;
  logic [8:0] adder_sum;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] m_regs [4];

  alu_operand_sequencer #(.DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .SrcA(SrcA), .SrcB(SrcB), .Dst(Dst),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .Aout(Aout), .Bout(Bout), .Add_Sub(Add_Sub),
    .R(R), .Cout(Cout), .OVR(OVR), .Neg(Neg), .Zero(Zero),
    .Result(Result), .Flags(Flags), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // Environment adder (the datapath this block drives)
  assign adder_sum = Add_Sub ? ({1'b0, Aout} + {1'b0, ~Bout} + 9'd1) : ({1'b0, Aout} + {1'b0, Bout});
  assign R    = adder_sum[7:0];
  assign Cout = adder_sum[8];
  assign OVR  = (Aout[7] == (Bout[7] ^ Add_Sub)) && (R[7] != Aout[7]);
  assign Neg  = R[7];
  assign Zero = (R == 8'h00);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, then optional saturation
  function automatic void model_op(input logic op, input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] w, output logic [3:0] f);
    int ua, ub, sa, sb, u, s;
    logic cout, ovr;
    logic [7:0] r;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    if (op) begin
      u = ua - ub; s = sa - sb; cout = (ua >= ub);
    end else begin
      u = ua + ub; s = sa + sb; cout = (u > 255);
    end
    r = 8'((u % 256 + 256) % 256);
    ovr = (s > 127) || (s < -128);
    f = {cout, ovr, r[7], (r == 8'h00)};
    w = r;
`ifdef ALU_SAT_WB_EN
    if (ovr) w = (sa < 0) ? 8'h80 : 8'h7F;
`endif
  endfunction

  task automatic load(input logic [1:0] addr, input logic [7:0] data);
    LoadEn = 1'b1; LoadAddr = addr; LoadData = data;
    m_regs[addr] = data;
    @(posedge Clock); #1;
    LoadEn = 1'b0;
  endtask

  task automatic run_op(input logic op, input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] dst,
                        input logic ld_en, input logic [1:0] la, input logic [7:0] ld,
                        output logic [7:0] res, output logic [3:0] flg);
    logic [7:0] a, b, exp_w;
    logic [3:0] exp_f;
    int cyc;
    if (ld_en) m_regs[la] = ld;
    a = m_regs[sa]; b = m_regs[sb];
    model_op(op, a, b, exp_w, exp_f);
    m_regs[dst] = exp_w;
    Start = 1'b1; Op = op; SrcA = sa; SrcB = sb; Dst = dst;
    LoadEn = ld_en; LoadAddr = la; LoadData = ld;
    @(posedge Clock); #1;
    Start = 1'b0; LoadEn = 1'b0;
    chk("busy_read", Busy, 1'b1);
    cyc = 1;
    while (!Done && cyc < 8) begin
      if (cyc == 2) begin
        chk("aout_exec", Aout, a);
        chk("bout_exec", Bout, b);
        chk("addsub_exec", Add_Sub, op);
      end
      @(posedge Clock); #1;
      cyc++;
    end
    chk("done_latency", cyc, 3);
    @(posedge Clock); #1;
    chk("done_clear", Done, 1'b0);
    chk("busy_clear", Busy, 1'b0);
    chk("result", Result, exp_w);
    chk("flags", Flags, exp_f);
    res = Result; flg = Flags;
  endtask

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] dst;
    logic [7:0] exp_r;
    logic [3:0] exp_f;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] res;
    logic [3:0] flg;
    logic sat;
`ifdef ALU_SAT_WB_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    vecs[0] = '{1'b0, 8'h05, 8'h03, 2'd2, 8'h08, 4'b0000};
    vecs[1] = '{1'b1, 8'h05, 8'h05, 2'd3, 8'h00, 4'b1001};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 2'd2, sat ? 8'h7F : 8'h80, 4'b0110};
    vecs[3] = '{1'b1, 8'h03, 8'h05, 2'd3, 8'hFE, 4'b0010};
    vecs[4] = '{1'b0, 8'hFF, 8'h01, 2'd2, 8'h00, 4'b1001};
    vecs[5] = '{1'b1, 8'h80, 8'h01, 2'd3, sat ? 8'h80 : 8'h7F, 4'b1100};
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

    #1 Reset = 1'b1;
    #2;
    chk("rst_aout", Aout, 8'h00);
    chk("rst_bout", Bout, 8'h00);
    chk("rst_addsub", Add_Sub, 1'b0);
    chk("rst_result", Result, 8'h00);
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      load(2'd0, vecs[i].a);
      load(2'd1, vecs[i].b);
      run_op(vecs[i].op, 2'd0, 2'd1, vecs[i].dst, 1'b0, 2'd0, 8'h00, res, flg);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp_r);
      chk($sformatf("vec%0d_flags", i), flg, vecs[i].exp_f);
    end
    // Destination written by the add vector is visible to a later read
    run_op(1'b0, 2'd2, 2'd2, 2'd1, 1'b0, 2'd0, 8'h00, res, flg);

    // Same-cycle load and start, SrcA == SrcB == LoadAddr
    run_op(1'b0, 2'd0, 2'd0, 2'd1, 1'b1, 2'd0, 8'h10, res, flg);
    chk("ldstart_result", res, 8'h20);

    // Start/LoadEn pulsed during EXEC are ignored
    load(2'd0, 8'h11);
    load(2'd1, 8'h22);
    Start = 1'b1; Op = 1'b0; SrcA = 2'd0; SrcB = 2'd1; Dst = 2'd2;
    @(posedge Clock); #1;
    Start = 1'b0;
    @(posedge Clock); #1;
    Start = 1'b1; SrcA = 2'd3; Dst = 2'd3; LoadEn = 1'b1; LoadAddr = 2'd0; LoadData = 8'hAA;
    @(posedge Clock); #1;
    Start = 1'b0; LoadEn = 1'b0;
    chk("busy_ign_done", Done, 1'b1);
    @(posedge Clock); #1;
    chk("busy_ign_result", Result, 8'h33);
    m_regs[2] = 8'h33;
    for (int k = 0; k < 4; k++) begin
      chk("busy_ign_idle_busy", Busy, 1'b0);
      chk("busy_ign_idle_done", Done, 1'b0);
      @(posedge Clock); #1;
    end
    run_op(1'b0, 2'd0, 2'd0, 2'd3, 1'b0, 2'd0, 8'h00, res, flg);
    chk("busy_ign_r0", res, 8'h22);

    // Reset in the middle of EXEC
    load(2'd0, 8'h21); load(2'd1, 8'h43); load(2'd2, 8'h65); load(2'd3, 8'h87);
    Start = 1'b1; Op = 1'b1; SrcA = 2'd0; SrcB = 2'd1; Dst = 2'd3;
    @(posedge Clock); #1;
    Start = 1'b0;
    @(posedge Clock); #1;
    chk("pre_rst_addsub", Add_Sub, 1'b1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_aout", Aout, 8'h00);
    chk("mid_rst_bout", Bout, 8'h00);
    chk("mid_rst_addsub", Add_Sub, 1'b0);
    chk("mid_rst_result", Result, 8'h00);
    chk("mid_rst_flags", Flags, 4'b0000);
    chk("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_done", Done, 1'b0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_done", Done, 1'b0);
      @(posedge Clock); #1;
    end
    run_op(1'b0, 2'd3, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00, res, flg);
    chk("post_rst_r3", res, 8'h00);
    run_op(1'b0, 2'd2, 2'd1, 2'd0, 1'b0, 2'd0, 8'h00, res, flg);

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) load(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 255)), res, flg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
